inc16_rr_arbiter: RTL and testbench
===================================

// Module: inc16_rr_arbiter
// PURPOSE
//  Shares one 16-bit +1 incrementer datapath among NREQ requesters.
//  Round-robin arbitration selects one requester per cycle; its operand is incremented and registered.
//  The result is presented on one valid/ready response channel with a requester ID and a carry-out.
//  Sits between address/counter generators (requesters) and the consumers of the incremented value.
// PARAMETERS
//  NREQ   4    number of requesters, 2..8
//  IDW    2    width of rsp_id; must equal ceil(log2(NREQ))
// PORTS
//  clk        in   1          rising-edge clock, sole clock domain
//  rst        in   1          asynchronous, active-high reset
//  req_valid  in   NREQ       requester i has an operand pending
//  req_data   in   16*NREQ    operand of requester i on bits [16*i+15:16*i]
//  req_ready  out  NREQ       one-hot; operand i taken this cycle
//  rsp_valid  out  1          response register holds a result
//  rsp_data   out  16         operand + 1, modulo 2^16
//  rsp_carry  out  1          1 when the operand was 16'hFFFF
//  rsp_id     out  IDW        index of the requester that produced the result
//  rsp_ready  in   1          consumer accepts the response this cycle
// BEHAVIOUR
//  - Reset (async assert, sync deassert internally):
//    - rsp_valid=0, rsp_data=0, rsp_carry=0, rsp_id=0, req_ready=0.
//    - RR pointer=0; state=EMPTY.
//  - FSM on the response register, states EMPTY and FULL:
//    - EMPTY -> FULL on grant.
//    - FULL -> EMPTY on drain (rsp_valid & rsp_ready) with no grant.
//    - FULL -> FULL on drain+grant in the same cycle (back-to-back), or on stall.
//  - accept = ~rsp_valid | rsp_ready (combinational).
//    - Grant only when accept & |req_valid.
//  - Arbitration: first set req_valid bit at or after the pointer, searching upward and wrapping at NREQ-1 -> 0.
//    - Pointer <= grant index + 1 (mod NREQ) only on grant; otherwise it holds.
//  - req_ready is combinational from req_valid, pointer and accept.
//    - At most one bit is set, and only when that requester's valid is high.
//  - Latency: operand taken in cycle N appears with rsp_valid=1 in cycle N+1.
//    - Throughput is 1 result per cycle while rsp_ready=1.
//  - Stall: while rsp_valid & ~rsp_ready, rsp_data/rsp_carry/rsp_id hold stable and req_ready=0.
//  - Requester rule: req_valid stays high and req_data stays stable until req_ready.
//    - The block does not check this rule.
//  - Wrap-around: 16'hFFFF -> rsp_data=16'h0000, rsp_carry=1.
//    - All other operands give rsp_carry=0.
//  - Reset mid-operation: any in-flight result is discarded; no partial response is emitted.
//  - No valid requests: no grant, pointer unchanged, register drains normally.
// STRUCTURE
//  - Shared package inc16_pkg holds:
//    - localparam INC16_W = 16;
//    - typedef for the response struct {data, carry, id};
//    - the EMPTY/FULL state encoding.
//  - Sub-module inc16_rr_pick: pointer + request vector -> one-hot grant and index (pure combinational).
//  - The incrementer is the team's existing ripple-carry +1 adder (add16_bit).
//    - Instance it once on the muxed operand.
//    - Carry-out is taken as &operand, since the adder does not export it.
// TESTING
//  1. Reset mid-FULL:
//     - Stimulus: assert rst while rsp_valid=1.
//     - Required: all outputs 0 within the same cycle; pointer=0 after release.
//  2. Single requester:
//     - Stimulus: req_valid=4'b0010, data1=16'h1234, rsp_ready=1.
//     - Required: req_ready=4'b0010 in cycle N; cycle N+1 gives rsp_data=16'h1235, id=1, carry=0.
//  3. Round-robin fairness:
//     - Stimulus: all four valid and held, rsp_ready=1.
//     - Required: grant order 0,1,2,3,0.
//  4. Wrap:
//     - Stimulus: data2=16'hFFFF.
//     - Required: rsp_data=16'h0000, carry=1, id=2.
//     - Stimulus: data2=16'h7FFF.
//     - Required: rsp_data=16'h8000, carry=0.
//  5. Backpressure:
//     - Stimulus: rsp_ready=0 for 3 cycles with req_valid=4'b1111.
//     - Required: req_ready=0 and response stable throughout.
//     - Then rsp_ready=1: drain and a new grant happen in the same cycle, with no bubble.
//  6. Sparse requests:
//     - Stimulus: pointer=3, req_valid=4'b0101.
//     - Required: grant 0, then 2.
//     - Stimulus: idle cycles with req_valid=0.
//     - Required: pointer unchanged, rsp_valid falls after the drain.

Source files
------------

// File: rtl/inc16_pkg.sv
// Shared types for the round-robin shared incrementer: datapath width,
// response register layout and the response-register state encoding.
package inc16_pkg;

    localparam int INC16_W  = 16;
    // Widest requester ID the block supports (NREQ up to 8).
    localparam int RSP_ID_W = 3;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } rsp_state_t;

    typedef struct packed {
        logic [INC16_W-1:0]  data;
        logic                carry;
        logic [RSP_ID_W-1:0] id;
    } rsp_t;

endpackage

// File: rtl/add16_bit.sv
// Ripple-carry +1 adder. Only the 16-bit sum is exported; callers that need
// the carry-out derive it from the operand.
module add16_bit
    import inc16_pkg::*;
(
    input  logic [INC16_W-1:0] a,
    output logic [INC16_W-1:0] sum
);

    logic c;

    always_comb begin
        c   = 1'b1;
        sum = '0;
        for (int i = 0; i < INC16_W; i++) begin
            sum[i] = a[i] ^ c;
            c      = c & a[i];
        end
    end

endmodule

// File: rtl/inc16_rr_pick.sv
// Round-robin picker: first set request at or above the pointer, wrapping at
// NREQ-1 back to 0. Pure combinational.
module inc16_rr_pick
    import inc16_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  idx,
    output logic            any
);

    int             cand;
    logic [IDW-1:0] cand_idx;

    always_comb begin
        grant    = '0;
        idx      = '0;
        any      = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = int'(ptr) + k;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            cand_idx = IDW'(cand);
            if (!any && req[cand_idx]) begin
                any             = 1'b1;
                grant[cand_idx] = 1'b1;
                idx             = cand_idx;
            end
        end
    end

endmodule

// File: rtl/inc16_rr_arbiter.sv
// Shares one +1 incrementer among NREQ requesters with round-robin arbitration
// and a single registered valid/ready response carrying the requester ID.
module inc16_rr_arbiter
    import inc16_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [INC16_W*NREQ-1:0] req_data,
    output logic [NREQ-1:0]         req_ready,
    output logic                    rsp_valid,
    output logic [INC16_W-1:0]      rsp_data,
    output logic                    rsp_carry,
    output logic [IDW-1:0]          rsp_id,
    input  logic                    rsp_ready
);

    // Handshake: a transfer happens on a channel in any cycle where both its
    // valid and ready are high; a producer holds valid and payload until then.

    logic [1:0] rst_sync;
    logic       rst_int;

    // Reset asserts immediately and releases two clock edges later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rst_sync <= 2'b11;
        end else begin
            rst_sync <= {rst_sync[0], 1'b0};
        end
    end

    assign rst_int = rst_sync[1];

    rsp_state_t         state_q;
    rsp_state_t         state_d;
    rsp_t               rsp_q;
    rsp_t               rsp_d;
    logic [IDW-1:0]     ptr_q;
    logic [IDW-1:0]     pick_idx;
    logic [NREQ-1:0]    pick_onehot;
    logic               pick_any;
    logic               accept;
    logic               grant_en;
    logic [INC16_W-1:0] operand;
    logic [INC16_W-1:0] sum;
    logic               unused_id_bits;

    inc16_rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req   (req_valid),
        .ptr   (ptr_q),
        .grant (pick_onehot),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    assign rsp_valid = (state_q == ST_FULL);
    assign accept    = ~rsp_valid | rsp_ready;
    assign grant_en  = accept & pick_any & ~rst_int;
    assign req_ready = grant_en ? pick_onehot : '0;

    always_comb begin
        operand = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_onehot[i]) begin
                operand = req_data[i*INC16_W +: INC16_W];
            end
        end
    end

    add16_bit u_add (
        .a   (operand),
        .sum (sum)
    );

    // The adder hides its carry-out; it is set exactly when the operand is all ones.
    always_comb begin
        rsp_d       = rsp_q;
        rsp_d.data  = sum;
        rsp_d.carry = &operand;
        rsp_d.id    = RSP_ID_W'(pick_idx);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (grant_en) state_d = ST_FULL;
            ST_FULL: begin
                if (grant_en) begin
                    state_d = ST_FULL;
                end else if (rsp_ready) begin
                    state_d = ST_EMPTY;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst_int) begin
        if (rst_int) begin
            state_q <= ST_EMPTY;
            rsp_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            if (grant_en) begin
                rsp_q <= rsp_d;
                ptr_q <= (pick_idx == IDW'(NREQ - 1)) ? '0 : pick_idx + IDW'(1);
            end
        end
    end

    assign rsp_data       = rsp_q.data;
    assign rsp_carry      = rsp_q.carry;
    assign rsp_id         = rsp_q.id[IDW-1:0];
    assign unused_id_bits = ^rsp_q.id;

endmodule

// File: tb/tb_inc16_rr_arbiter.sv
// Self-checking bench for inc16_rr_arbiter: directed scenarios plus a random
// run scored against a queue-based reference model.
module tb_inc16_rr_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int W    = 16;
    localparam int RW   = W + 1 + IDW;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic [NREQ-1:0]     req_valid = '0;
    logic [W*NREQ-1:0]   req_data = '0;
    logic [NREQ-1:0]     req_ready;
    logic                rsp_valid;
    logic [W-1:0]        rsp_data;
    logic                rsp_carry;
    logic [IDW-1:0]      rsp_id;
    logic                rsp_ready = 1'b0;

    int checks = 0;
    int errors = 0;
    int m_ptr  = 0;
    logic [RW-1:0] exp_q[$];

    inc16_rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_carry (rsp_carry),
        .rsp_id    (rsp_id),
        .rsp_ready (rsp_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    function automatic int model_pick(input logic [NREQ-1:0] v, input int ptr);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [RW-1:0] model_rsp(input logic [W-1:0] op, input int id);
        logic [W:0]     s;
        logic [IDW-1:0] idv;
        s   = {1'b0, op} + 17'd1;
        idv = IDW'(id);
        return {s[W-1:0], s[W], idv};
    endfunction

    task automatic predict(output logic [NREQ-1:0] er, output int g);
        er = '0;
        g  = -1;
        if (exp_q.size() == 0 || rsp_ready) begin
            g = model_pick(req_valid, m_ptr);
            if (g >= 0) er[g] = 1'b1;
        end
    endtask

    task automatic advance(input int g);
        bit         drain;
        logic [W-1:0] op;
        drain = (exp_q.size() != 0) && rsp_ready;
        op    = '0;
        if (g >= 0) op = req_data[g*W +: W];
        @(posedge clk);
        if (drain) void'(exp_q.pop_front());
        if (g >= 0) begin
            exp_q.push_back(model_rsp(op, g));
            m_ptr = (g + 1) % NREQ;
        end
        #1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req_valid = '0;
        rsp_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (3) tick();
        exp_q.delete();
        m_ptr = 0;
    endtask

    task automatic rand_data();
        for (int i = 0; i < NREQ; i++) req_data[i*W +: W] = 16'($urandom);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rand_data();
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        #1 rst = 1'b1;
        #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", rsp_valid); end
        checks++; if (rsp_data !== 16'h0000) begin errors++; $display("FAIL reset_data got %h exp 0000", rsp_data); end
        checks++; if (rsp_carry !== 1'b0 || rsp_id !== 2'd0) begin errors++; $display("FAIL reset_carry_id got %b/%0d exp 0/0", rsp_carry, rsp_id); end
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready got %b exp 0000", req_ready); end
        repeat (2) tick();
        checks++; if (req_ready !== 4'b0000 || rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_held got rdy %b vld %b exp 0000/0", req_ready, rsp_valid); end
        rst = 1'b0;
        for (int k = 0; k < 6 && req_ready == 4'b0000; k++) tick();
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL reset_first_grant got %b exp 0001", req_ready); end
        do_reset();
    endtask

    task automatic test_single();
        do_reset();
        rand_data();
        req_data[1*W +: W] = 16'h1234;
        req_valid = 4'b0010;
        rsp_ready = 1'b1;
        #2;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL single_grant got %b exp 0010", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid got %b exp 0", rsp_valid); end
        tick();
        req_valid = 4'b0000;
        #2;
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b exp 1", rsp_valid); end
        checks++; if (rsp_data !== 16'h1235 || rsp_id !== 2'd1 || rsp_carry !== 1'b0) begin
            errors++; $display("FAIL single_rsp got %h/%0d/%b exp 1235/1/0", rsp_data, rsp_id, rsp_carry); end
        tick();
        #2;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_drain got %b exp 0", rsp_valid); end
    endtask

    task automatic test_rr_fairness();
        int order[5] = '{0, 1, 2, 3, 0};
        logic [NREQ-1:0] er;
        logic [W-1:0]    ed;
        do_reset();
        rand_data();
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #2;
            er = '0;
            er[order[c]] = 1'b1;
            checks++; if (req_ready !== er) begin errors++; $display("FAIL rr_grant%0d got %b exp %b", c, req_ready, er); end
            if (c > 0) begin
                ed = req_data[order[c-1]*W +: W] + 16'd1;
                checks++; if (rsp_valid !== 1'b1 || rsp_id !== IDW'(order[c-1]) || rsp_data !== ed) begin
                    errors++; $display("FAIL rr_rsp%0d got %b/%0d/%h exp 1/%0d/%h", c, rsp_valid, rsp_id, rsp_data, order[c-1], ed); end
            end
            tick();
        end
        req_valid = '0;
        repeat (2) tick();
    endtask

    task automatic test_wrap();
        do_reset();
        rand_data();
        req_data[2*W +: W] = 16'hFFFF;
        req_valid = 4'b0100;
        rsp_ready = 1'b1;
        #2;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL wrap_grant got %b exp 0100", req_ready); end
        tick();
        req_data[2*W +: W] = 16'h7FFF;
        #2;
        checks++; if (rsp_data !== 16'h0000 || rsp_carry !== 1'b1 || rsp_id !== 2'd2) begin
            errors++; $display("FAIL wrap_ffff got %h/%b/%0d exp 0000/1/2", rsp_data, rsp_carry, rsp_id); end
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL wrap_regrant got %b exp 0100", req_ready); end
        tick();
        req_valid = '0;
        #2;
        checks++; if (rsp_data !== 16'h8000 || rsp_carry !== 1'b0 || rsp_id !== 2'd2) begin
            errors++; $display("FAIL wrap_7fff got %h/%b/%0d exp 8000/0/2", rsp_data, rsp_carry, rsp_id); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] e0;
        logic [W-1:0] e1;
        do_reset();
        rand_data();
        e0 = req_data[0*W +: W] + 16'd1;
        e1 = req_data[1*W +: W] + 16'd1;
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #2;
            checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL stall_ready%0d got %b exp 0000", c, req_ready); end
            checks++; if (rsp_valid !== 1'b1 || rsp_data !== e0 || rsp_id !== 2'd0) begin
                errors++; $display("FAIL stall_hold%0d got %b/%h/%0d exp 1/%h/0", c, rsp_valid, rsp_data, rsp_id, e0); end
            tick();
        end
        rsp_ready = 1'b1;
        #2;
        checks++; if (req_ready !== 4'b0010 || rsp_valid !== 1'b1) begin
            errors++; $display("FAIL b2b_grant got %b/%b exp 0010/1", req_ready, rsp_valid); end
        tick();
        req_valid = '0;
        #2;
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== e1) begin
            errors++; $display("FAIL b2b_next got %b/%0d/%h exp 1/1/%h", rsp_valid, rsp_id, rsp_data, e1); end
        repeat (2) tick();
    endtask

    task automatic test_sparse();
        do_reset();
        rand_data();
        req_valid = 4'b0100;
        rsp_ready = 1'b1;
        tick();
        req_valid = 4'b0101;
        #2;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL sparse_first got %b exp 0001", req_ready); end
        tick();
        req_valid = 4'b0100;
        #2;
        checks++; if (req_ready !== 4'b0100 || rsp_id !== 2'd0) begin
            errors++; $display("FAIL sparse_second got %b/%0d exp 0100/0", req_ready, rsp_id); end
        tick();
        req_valid = 4'b0000;
        #2;
        checks++; if (req_ready !== 4'b0000 || rsp_valid !== 1'b1 || rsp_id !== 2'd2) begin
            errors++; $display("FAIL sparse_idle got %b/%b/%0d exp 0000/1/2", req_ready, rsp_valid, rsp_id); end
        tick();
        #2;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL sparse_drain got %b exp 0", rsp_valid); end
        repeat (2) tick();
        req_valid = 4'b1111;
        #2;
        checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL sparse_ptr_hold got %b exp 1000", req_ready); end
        tick();
        req_valid = '0;
        repeat (2) tick();
    endtask

    task automatic test_reset_mid_full();
        do_reset();
        rand_data();
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        #2;
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL midrst_pre got %b exp 1", rsp_valid); end
        rst = 1'b1;
        #1;
        checks++; if (rsp_valid !== 1'b0 || rsp_data !== 16'h0000 || rsp_carry !== 1'b0 || rsp_id !== 2'd0 || req_ready !== 4'b0000) begin
            errors++; $display("FAIL midrst_outputs got %b/%h/%b/%0d/%b exp all 0", rsp_valid, rsp_data, rsp_carry, rsp_id, req_ready); end
        tick();
        rst = 1'b0;
        rsp_ready = 1'b1;
        for (int k = 0; k < 6 && req_ready == 4'b0000; k++) tick();
        checks++; if (req_ready !== 4'b0001 || rsp_valid !== 1'b0) begin
            errors++; $display("FAIL midrst_after got %b/%b exp 0001/0", req_ready, rsp_valid); end
        do_reset();
    endtask

    task automatic test_random();
        logic [NREQ-1:0] er;
        int              g;
        localparam int NCYC = 400;
        do_reset();
        rand_data();
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            #2;
            predict(er, g);
            checks++; if (req_ready !== er) begin errors++; $display("FAIL rand_ready cyc %0d got %b exp %b", cyc, req_ready, er); end
            checks++; if (rsp_valid !== (exp_q.size() != 0)) begin
                errors++; $display("FAIL rand_valid cyc %0d got %b exp %0d", cyc, rsp_valid, exp_q.size()); end
            if (exp_q.size() != 0) begin
                checks++; if ({rsp_data, rsp_carry, rsp_id} !== exp_q[0]) begin
                    errors++; $display("FAIL rand_rsp cyc %0d got %h/%b/%0d exp %h", cyc, rsp_data, rsp_carry, rsp_id, exp_q[0]); end
            end
            advance(g);
            if (g >= 0) req_valid[g] = 1'b0;
            if (cyc < NCYC - 4) begin
                for (int i = 0; i < NREQ; i++) begin
                    if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
                        req_valid[i] = 1'b1;
                        req_data[i*W +: W] = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
                    end
                end
                rsp_ready = ($urandom_range(0, 3) != 0);
            end else begin
                req_valid = '0;
                rsp_ready = 1'b1;
            end
        end
        #2;
        checks++; if (rsp_valid !== 1'b0 || exp_q.size() != 0) begin
            errors++; $display("FAIL rand_final got %b/%0d exp 0/0", rsp_valid, exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_rr_fairness();
        test_wrap();
        test_back_to_back();
        test_sparse();
        test_reset_mid_full();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
